rng_scheduler: RTL and testbench

//  Shares one free-running rng (8-bit LFSR output) among NUM_REQ game requesters (dice, spawn, AI).

---
 rtl/rng_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/rng_scheduler.sv | 121 ++++++++++++
 tb/tb_rng_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and helpers for the rng request scheduler
package rng_pkg;

    localparam int RNG_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        RESP
    } state_e;

    // Smallest all-ones value covering bound-1, so masked draws stay below 2*bound.
    function automatic logic [RNG_W-1:0] mask_for_bound(input logic [RNG_W-1:0] bound);
        logic [RNG_W-1:0] m;
        m = bound - RNG_W'(1);
        for (int i = 0; i < RNG_W; i++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rng_scheduler.sv
// rtl/rng_scheduler.sv - shares one rng among requesters with bounded rejection sampling
module rng_scheduler
    import rng_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = RNG_W,
    parameter int MAX_TRIES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rnd_in,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_bound,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [PW-1:0]        g_q, g_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     bound_q, bound_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [3:0]           tries_q, tries_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic [WIDTH-1:0]     cand;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign cand = rnd_in & mask_q;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        bound_d     = bound_q;
        mask_d      = mask_q;
        tries_d     = tries_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    // Grant is combinational, so hold it off while reset is asserted.
                    req_ready = reset ? '0 : arb_grant;
                    g_d       = arb_idx;
                    bound_d   = req_bound[int'(arb_idx)*WIDTH +: WIDTH];
                    mask_d    = mask_for_bound(bound_d);
                    rr_ptr_d  = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
                    tries_d   = '0;
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                if (bound_q == '0) begin
                    rsp_data_d = rnd_in;
                    state_d    = RESP;
                end else if (cand < bound_q) begin
                    rsp_data_d = cand;
                    state_d    = RESP;
                end else if (tries_q == 4'(MAX_TRIES - 1)) begin
                    rsp_data_d = cand - bound_q;
                    state_d    = RESP;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
                if (state_d == RESP) begin
                    rsp_valid_d = NUM_REQ'(1) << g_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            bound_q     <= '0;
            mask_q      <= '0;
            tries_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            bound_q     <= bound_d;
            mask_q      <= mask_d;
            tries_q     <= tries_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rng_scheduler.sv
// tb/tb_rng_scheduler.sv - randomized and directed checks of rng_scheduler against a reference model
module tb_rng_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MT = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   rnd_in;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_bound;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int n_chk = 0;
    int n_pass = 0;

    rng_scheduler #(.NUM_REQ(N), .WIDTH(W), .MAX_TRIES(MT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd_in    (rnd_in),
        .req_valid (req_valid),
        .req_bound (req_bound),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_mask(input int b);
        int k;
        k = 0;
        while (((1 << k) - 1) < (b - 1)) k++;
        return (1 << k) - 1;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference: one draw in flight, judged each cycle from the sampling rules.
    int m_rr = 0;
    bit m_draw = 0;
    bit m_resp = 0;
    int m_g = 0;
    int m_bound = 0;
    int m_tries = 0;
    int m_last = 0;

    always @(negedge clk) begin
        int g;
        int e_ready;
        int e_rv;
        int jj;
        int cand;
        if (reset) begin
            check("reset_req_ready", int'(req_ready), 0);
            check("reset_rsp_valid", int'(rsp_valid), 0);
            check("reset_rsp_data", int'(rsp_data), 0);
            check("reset_busy", int'(busy), 0);
            m_rr = 0; m_draw = 0; m_resp = 0; m_last = 0;
        end else begin
            g = -1;
            if (!m_draw && !m_resp) begin
                for (int k = 0; k < N; k++) begin
                    jj = (m_rr + k) % N;
                    if (g < 0 && req_valid[jj]) g = jj;
                end
            end
            e_ready = (g >= 0) ? (1 << g) : 0;
            e_rv = m_resp ? (1 << m_g) : 0;
            check("model_req_ready", int'(req_ready), e_ready);
            check("model_rsp_valid", int'(rsp_valid), e_rv);
            check("model_rsp_data", int'(rsp_data), m_last);
            check("model_busy", int'(busy), int'(m_draw || m_resp));
            if (m_resp) begin
                m_resp = 0;
            end else if (m_draw) begin
                cand = int'(rnd_in) & model_mask(m_bound);
                if (m_bound == 0) begin
                    m_last = int'(rnd_in); m_draw = 0; m_resp = 1;
                end else if (cand < m_bound) begin
                    m_last = cand; m_draw = 0; m_resp = 1;
                end else if (m_tries == MT - 1) begin
                    m_last = cand - m_bound; m_draw = 0; m_resp = 1;
                end else begin
                    m_tries++;
                end
            end else if (g >= 0) begin
                m_draw = 1; m_g = g; m_bound = int'(req_bound[g*W +: W]);
                m_rr = (g + 1) % N; m_tries = 0;
            end
        end
    end

    int gnt_idx[$];
    int gnt_cyc[$];
    logic [N-1:0] gs;
    bit early2;
    int b;

    initial begin
        rnd_in = '0;
        req_valid = '1;
        req_bound = '0;
        check("mask_6", model_mask(6), 7);
        check("mask_1", model_mask(1), 0);
        check("mask_128", model_mask(128), 127);

        @(negedge clk);
        check("rst_ready_gated", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        req_valid = '0;
        tick();

        // bound 6: rejects 7 and 6, accepts 3
        req_valid = 4'b0001; req_bound[0 +: W] = 8'd6; rnd_in = 8'hFF;
        @(negedge clk); check("b6_grant", int'(req_ready), 1);
        tick(); req_valid = '0; rnd_in = 8'hFF;
        @(negedge clk); check("b6_busy", int'(busy), 1);
        tick(); rnd_in = 8'h0E;
        tick(); rnd_in = 8'h03;
        tick();
        @(negedge clk);
        check("b6_rsp_valid", int'(rsp_valid), 1);
        check("b6_rsp_data", int'(rsp_data), 3);
        tick();

        // bound 0 returns raw value
        req_valid = 4'b0010; req_bound[W +: W] = 8'd0; rnd_in = 8'hA5;
        @(negedge clk); check("b0_grant", int'(req_ready), 2);
        tick(); req_valid = '0;
        tick();
        @(negedge clk);
        check("b0_rsp_valid", int'(rsp_valid), 2);
        check("b0_rsp_data", int'(rsp_data), 8'hA5);
        tick();

        // bound 1 always yields 0
        req_valid = 4'b0100; req_bound[2*W +: W] = 8'd1; rnd_in = W'($urandom);
        @(negedge clk); check("b1_grant", int'(req_ready), 4);
        tick(); req_valid = '0; rnd_in = W'($urandom);
        tick();
        @(negedge clk);
        check("b1_rsp_valid", int'(rsp_valid), 4);
        check("b1_rsp_data", int'(rsp_data), 0);
        tick();

        // bound 5 with 0x07 held: fallback after MAX_TRIES attempts
        req_valid = 4'b1000; req_bound[3*W +: W] = 8'd5; rnd_in = 8'h07;
        @(negedge clk); check("fb_grant", int'(req_ready), 8);
        tick(); req_valid = '0;
        for (int i = 0; i < MT; i++) begin
            @(negedge clk);
            check("fb_draw_busy", int'(busy), 1);
            check("fb_draw_no_rsp", int'(rsp_valid), 0);
            tick();
        end
        @(negedge clk);
        check("fb_rsp_valid", int'(rsp_valid), 8);
        check("fb_rsp_data", int'(rsp_data), 2);
        tick();

        // all requesters held high from reset
        reset = 1'b1; req_valid = '1;
        for (int i = 0; i < N; i++) req_bound[i*W +: W] = 8'd3;
        @(negedge clk); check("rr_rst_busy", int'(busy), 0);
        tick(); reset = 1'b0;
        for (int c = 0; c < 100 && gnt_idx.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin gnt_idx.push_back(first_set(req_ready)); gnt_cyc.push_back(c); end
            tick(); rnd_in = W'($urandom);
        end
        check("rr_grant_count", gnt_idx.size(), 5);
        for (int i = 0; i < gnt_idx.size(); i++) begin
            check("rr_order", gnt_idx[i], i % N);
            if (i > 0) check("rr_gap_ge3", int'(gnt_cyc[i] - gnt_cyc[i-1] >= 3), 1);
        end

        // reset mid-DRAW for req2, then re-grant in rr_ptr=0 order
        reset = 1'b1; req_valid = 4'b0100; req_bound[2*W +: W] = 8'd200; rnd_in = 8'hFF;
        tick(); reset = 1'b0;
        @(negedge clk); check("mid_grant2", int'(req_ready), 4);
        tick();
        tick();
        reset = 1'b1; req_valid = 4'b0111;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        tick(); reset = 1'b0;
        gnt_idx.delete();
        early2 = 1'b0;
        for (int c = 0; c < 100 && gnt_idx.size() < 3; c++) begin
            @(negedge clk);
            gs = req_ready;
            if (rsp_valid[2]) early2 = 1'b1;
            if (gs != '0) gnt_idx.push_back(first_set(gs));
            tick();
            req_valid = req_valid & ~gs;
            rnd_in = W'($urandom);
        end
        check("mid_regrant_count", gnt_idx.size(), 3);
        for (int i = 0; i < gnt_idx.size(); i++) check("mid_regrant_order", gnt_idx[i], i);
        check("mid_no_stale_rsp2", int'(early2), 0);
        req_valid = '0;

        // randomized traffic with withdrawals and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gs = req_ready;
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(499) == 0) reset = 1'b1;
            if ($urandom_range(3) != 0) rnd_in = W'($urandom);
            for (int i = 0; i < N; i++) begin
                if (gs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    case ($urandom_range(5))
                        0: b = 0;
                        1: b = 1;
                        2: b = 128;
                        3: b = 255;
                        default: b = int'($urandom_range(255));
                    endcase
                    req_bound[i*W +: W] = W'(b);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
